fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Dual-width instruction buffer between the fetch/branch-presolve stage and decode.
- Accepts one fetch pack per cycle: an 8-byte-aligned PC, two 32-bit instructions, per-slot valids and the branch-predict pack. Only the valid slots are written, compacted in program order.
- Presents up to two oldest instructions per cycle to decode, each with its PC and predicted-taken flag.
- Absorbs decode back-pressure. Cleared by a backend/presolve redirect flush.

Parameters:
- DEPTH, 16, number of instruction entries; power of two, >= 4.
- PTR_W, log2(DEPTH), width of the head and tail pointers.

Ports:
- clock  input  1  the single clock.
- reset  input  1  asynchronous, active-low reset.
- io_i_flush  input  1  discard all queued entries and any pack offered this cycle.
- io_i_fetch_pack_valid  input  1  fetch pack offered.
- io_o_fetch_pack_ready  output  1  queue can take a full two-slot pack.
- io_i_fetch_pack_valids_0 / io_i_fetch_pack_valids_1  input  1 each  slot valids.
- io_i_fetch_pack_pc  input  64  pack PC; bits [2:0] are ignored.
- io_i_fetch_pack_insts_0 / io_i_fetch_pack_insts_1  input  32 each  slot instructions.
- io_i_fetch_pack_branch_predict_pack_valid, _select, _taken  input  1 each  predictor result; select indexes the slot.
- io_o_decode_valids_0 / io_o_decode_valids_1  output  1 each  head entries valid.
- io_o_decode_insts_0 / io_o_decode_insts_1  output  32 each  head instructions.
- io_o_decode_pcs_0 / io_o_decode_pcs_1  output  64 each  head PCs.
- io_o_decode_pred_taken_0 / io_o_decode_pred_taken_1  output  1 each  predicted-taken flags.
- io_i_decode_ready  input  1  decode consumes every presented valid entry this cycle.

Behaviour:
- Storage: DEPTH entries of {inst[31:0], pc[63:0], pred_taken}, organised as a circular buffer.
  - State: head, tail (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits, 0..DEPTH).
- Reset: head = tail = count = 0; outputs read io_o_decode_valids_* = 0 and io_o_fetch_pack_ready = 1. Entry contents are don't-care.
- io_o_fetch_pack_ready = (DEPTH - count >= 2). It is derived from registered count only and does not depend on io_i_decode_ready.
- Enqueue fires when fetch_pack_valid & ready & !flush.
  - Slot PCs: slot0 PC = {pc[63:3],3'b000}; slot1 PC = that value + 4.
  - Write order: valids_0 is written at tail, then valids_1 at the next index.
  - valids = 2'b10 writes only slot1, at tail.
  - valids = 2'b00 fires but writes nothing.
  - Tail and count advance by the number of valid slots.
- pred_taken of a written slot = branch_predict_pack_valid & taken & (select == slot index). Other slots store 0.
- Decode outputs are combinational reads of entries at head and head+1 (mod DEPTH).
  - valids_0 = (count >= 1); valids_1 = (count >= 2).
  - An enqueued instruction is visible to decode the cycle after the enqueue. There is no same-cycle bypass.
- Dequeue when io_i_decode_ready & !flush: head advances by valids_0 + valids_1 (0, 1 or 2); count decreases by the same amount.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Full and empty are judged on current count, so no entry is lost or duplicated.
- Flush has the highest priority: next cycle head = tail = count = 0. Any enqueue or dequeue in the flush cycle is ignored.
- Count = DEPTH-1: ready = 0 even if decode is draining this cycle.
- Wrap-around: the two written slots and the two read slots may straddle index DEPTH-1 -> 0.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronously).

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- When defined, the block adds three output ports:
  - io_o_perf_full_cycles, 32 bits: increments each cycle io_i_fetch_pack_valid & !ready.
  - io_o_perf_empty_cycles, 32 bits: increments each cycle count == 0 & !flush.
  - io_o_perf_flushes, 32 bits: increments each cycle io_i_flush is asserted.
- The counters saturate at 0xFFFFFFFF and are cleared by reset only.
- When not defined, these ports and counters are absent and the block behaves identically otherwise.

Test Plan:
- Enqueue: reset, then one pack pc=0x80000004, valids=11, insts A,B, decode_ready=0 -> next cycle valids_0/1 = 1/1, pcs 0x80000000 / 0x80000004, count = 2.
- Compaction: pack valids=10, inst B at pc=0x1000, bp valid=1 select=1 taken=1 -> entry0 = B, pc 0x1004, pred_taken_0 = 1, valids_1 = 0.
- Fill and wrap: DEPTH=16, enqueue 8 full packs with decode_ready=0 -> ready = 0 at count 16. Then assert decode_ready -> 2 instructions per cycle in program order, with correct wrap past index 15.
- Full boundary: count 15, offer a pack while decode drains 2 -> pack not accepted (ready = 0), count 13 next cycle.
- Flush: count 6, flush asserted together with a valid pack and decode_ready=1 -> next cycle count = 0, valids_0 = 0, no decode handshake counted.
- Reset mid-traffic: drop reset to 0 with count 5 -> outputs immediately read valids 0 and ready 1. After release, the first enqueue lands at index 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-pack and decode handshake bundle for the fetch queue.
// Latency: none, wires only.
// Backpressure: carries fetch_pack_ready upstream and decode_ready from decode.
interface fetch_queue_if;
  // flush from backend/presolve redirect
  logic        io_i_flush;
  // fetch pack
  logic        io_i_fetch_pack_valid;
  logic        io_o_fetch_pack_ready;
  logic        io_i_fetch_pack_valids_0;
  logic        io_i_fetch_pack_valids_1;
  logic [63:0] io_i_fetch_pack_pc;
  logic [31:0] io_i_fetch_pack_insts_0;
  logic [31:0] io_i_fetch_pack_insts_1;
  logic        io_i_fetch_pack_branch_predict_pack_valid;
  logic        io_i_fetch_pack_branch_predict_pack_select;
  logic        io_i_fetch_pack_branch_predict_pack_taken;
  // decode side
  logic        io_o_decode_valids_0;
  logic        io_o_decode_valids_1;
  logic [31:0] io_o_decode_insts_0;
  logic [31:0] io_o_decode_insts_1;
  logic [63:0] io_o_decode_pcs_0;
  logic [63:0] io_o_decode_pcs_1;
  logic        io_o_decode_pred_taken_0;
  logic        io_o_decode_pred_taken_1;
  logic        io_i_decode_ready;

  // The queue itself.
  modport slave (
    input  io_i_flush,
    input  io_i_fetch_pack_valid,
    output io_o_fetch_pack_ready,
    input  io_i_fetch_pack_valids_0,
    input  io_i_fetch_pack_valids_1,
    input  io_i_fetch_pack_pc,
    input  io_i_fetch_pack_insts_0,
    input  io_i_fetch_pack_insts_1,
    input  io_i_fetch_pack_branch_predict_pack_valid,
    input  io_i_fetch_pack_branch_predict_pack_select,
    input  io_i_fetch_pack_branch_predict_pack_taken,
    output io_o_decode_valids_0,
    output io_o_decode_valids_1,
    output io_o_decode_insts_0,
    output io_o_decode_insts_1,
    output io_o_decode_pcs_0,
    output io_o_decode_pcs_1,
    output io_o_decode_pred_taken_0,
    output io_o_decode_pred_taken_1,
    input  io_i_decode_ready
  );

  // The surroundings: fetch, decode and the flush source.
  modport master (
    output io_i_flush,
    output io_i_fetch_pack_valid,
    input  io_o_fetch_pack_ready,
    output io_i_fetch_pack_valids_0,
    output io_i_fetch_pack_valids_1,
    output io_i_fetch_pack_pc,
    output io_i_fetch_pack_insts_0,
    output io_i_fetch_pack_insts_1,
    output io_i_fetch_pack_branch_predict_pack_valid,
    output io_i_fetch_pack_branch_predict_pack_select,
    output io_i_fetch_pack_branch_predict_pack_taken,
    input  io_o_decode_valids_0,
    input  io_o_decode_valids_1,
    input  io_o_decode_insts_0,
    input  io_o_decode_insts_1,
    input  io_o_decode_pcs_0,
    input  io_o_decode_pcs_1,
    input  io_o_decode_pred_taken_0,
    input  io_o_decode_pred_taken_1,
    output io_i_decode_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: dual-slot circular instruction buffer between fetch and decode.
// Latency: an accepted instruction is visible at the decode outputs one cycle later (no bypass).
// Backpressure: takes a pack only with room for two entries; decode_ready pops every shown entry.
// Optional: define FETCH_QUEUE_PERF_EN for saturating full/empty/flush cycle counter outputs.
module fetch_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0] io_o_perf_full_cycles,
  output logic [31:0] io_o_perf_empty_cycles,
  output logic [31:0] io_o_perf_flushes,
`endif
  fetch_queue_if.slave io
);

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        predTaken;
  } entry_t;

  // Highest count that still leaves room for a full two-slot pack.
  localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 2);

  entry_t           entries [DEPTH];
  logic [PTR_W-1:0] headQ;
  logic [PTR_W-1:0] tailQ;
  logic [PTR_W:0]   countQ;

  logic             fetchReady;
  logic             enqFire;
  logic             deqFire;
  logic             headValid0;
  logic             headValid1;
  logic [1:0]       nEnq;
  logic [1:0]       nDeq;
  logic [63:0]      slotBasePc;
  entry_t           slotEntry0;
  entry_t           slotEntry1;
  logic             wrEn0;
  logic             wrEn1;
  logic [PTR_W-1:0] wrIdx1;
  logic [PTR_W-1:0] headIdx1;
  entry_t           rdEntry0;
  entry_t           rdEntry1;

  // Ready is judged on the registered count alone so it never depends on decode.
  assign fetchReady = (countQ <= READY_MAX);
  assign enqFire    = io.io_i_fetch_pack_valid & fetchReady & ~io.io_i_flush;
  assign deqFire    = io.io_i_decode_ready & ~io.io_i_flush;
  assign headValid0 = (countQ != '0);
  assign headValid1 = (countQ >= (PTR_W + 1)'(2));

  // Build the two candidate entries and the compacted write positions.
  always_comb begin
    nEnq       = 2'd0;
    nDeq       = 2'd0;
    slotBasePc = io.io_i_fetch_pack_pc & ~64'h7;
    slotEntry0 = '0;
    slotEntry1 = '0;
    wrEn0      = 1'b0;
    wrEn1      = 1'b0;
    wrIdx1     = tailQ;

    slotEntry0.inst      = io.io_i_fetch_pack_insts_0;
    slotEntry0.pc        = slotBasePc;
    slotEntry0.predTaken = io.io_i_fetch_pack_branch_predict_pack_valid
                         & io.io_i_fetch_pack_branch_predict_pack_taken
                         & ~io.io_i_fetch_pack_branch_predict_pack_select;
    slotEntry1.inst      = io.io_i_fetch_pack_insts_1;
    slotEntry1.pc        = slotBasePc + 64'd4;
    slotEntry1.predTaken = io.io_i_fetch_pack_branch_predict_pack_valid
                         & io.io_i_fetch_pack_branch_predict_pack_taken
                         & io.io_i_fetch_pack_branch_predict_pack_select;

    // Slot1 lands right after slot0 when both are valid, else directly at tail.
    wrIdx1 = tailQ + PTR_W'(io.io_i_fetch_pack_valids_0);
    wrEn0  = enqFire & io.io_i_fetch_pack_valids_0;
    wrEn1  = enqFire & io.io_i_fetch_pack_valids_1;

    if (enqFire) begin
      nEnq = {1'b0, io.io_i_fetch_pack_valids_0} + {1'b0, io.io_i_fetch_pack_valids_1};
    end
    if (deqFire) begin
      nDeq = {1'b0, headValid0} + {1'b0, headValid1};
    end
  end

  // Entry storage: contents need no reset, validity comes from count.
  always_ff @(posedge clock) begin
    if (wrEn0) begin
      entries[tailQ] <= slotEntry0;
    end
    if (wrEn1) begin
      entries[wrIdx1] <= slotEntry1;
    end
  end

  // Head/tail/count bookkeeping; flush beats both enqueue and dequeue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else if (io.io_i_flush) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      headQ  <= headQ + PTR_W'(nDeq);
      tailQ  <= tailQ + PTR_W'(nEnq);
      countQ <= countQ + (PTR_W + 1)'(nEnq) - (PTR_W + 1)'(nDeq);
    end
  end

  // Decode sees the two oldest entries, wrapping past the last index.
  assign headIdx1 = headQ + PTR_W'(1);
  assign rdEntry0 = entries[headQ];
  assign rdEntry1 = entries[headIdx1];

  assign io.io_o_fetch_pack_ready    = fetchReady;
  assign io.io_o_decode_valids_0     = headValid0;
  assign io.io_o_decode_valids_1     = headValid1;
  assign io.io_o_decode_insts_0      = rdEntry0.inst;
  assign io.io_o_decode_insts_1      = rdEntry1.inst;
  assign io.io_o_decode_pcs_0        = rdEntry0.pc;
  assign io.io_o_decode_pcs_1        = rdEntry1.pc;
  assign io.io_o_decode_pred_taken_0 = rdEntry0.predTaken & headValid0;
  assign io.io_o_decode_pred_taken_1 = rdEntry1.predTaken & headValid1;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perfFullQ;
  logic [31:0] perfEmptyQ;
  logic [31:0] perfFlushQ;

  function automatic logic [31:0] satInc(input logic [31:0] val, input logic hit);
    satInc = (hit && val != 32'hFFFF_FFFF) ? val + 32'd1 : val;
  endfunction

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perfFullQ  <= '0;
      perfEmptyQ <= '0;
      perfFlushQ <= '0;
    end else begin
      perfFullQ  <= satInc(perfFullQ, io.io_i_fetch_pack_valid & ~fetchReady);
      perfEmptyQ <= satInc(perfEmptyQ, ~headValid0 & ~io.io_i_flush);
      perfFlushQ <= satInc(perfFlushQ, io.io_i_flush);
    end
  end

  assign io_o_perf_full_cycles  = perfFullQ;
  assign io_o_perf_empty_cycles = perfEmptyQ;
  assign io_o_perf_flushes      = perfFlushQ;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue against a queue-based reference model.
// Latency: model entries become visible the cycle after the accepting edge.
// Backpressure: model accepts a pack only when at least two free entries exist.
module tb_fetch_queue;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        pt;
  } mentry_t;

  logic clock;
  logic reset;
  fetch_queue_if fqIf();

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perfFull, perfEmpty, perfFlush;
  logic [31:0] mFull, mEmpty, mFlush;
`endif

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
`ifdef FETCH_QUEUE_PERF_EN
    .io_o_perf_full_cycles  (perfFull),
    .io_o_perf_empty_cycles (perfEmpty),
    .io_o_perf_flushes      (perfFlush),
`endif
    .io    (fqIf)
  );

  int nCmp = 0;
  int nErr = 0;
  mentry_t mq[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of instructions, updated on each edge.
  always @(posedge clock or negedge reset) begin : model
    int  sz;
    bit  rdy;
    logic [63:0] base;
    if (!reset) begin
      mq.delete();
`ifdef FETCH_QUEUE_PERF_EN
      mFull = 0; mEmpty = 0; mFlush = 0;
`endif
    end else begin
      sz   = mq.size();
      rdy  = (DEPTH - sz >= 2);
      base = {fqIf.io_i_fetch_pack_pc[63:3], 3'b000};
`ifdef FETCH_QUEUE_PERF_EN
      if (fqIf.io_i_fetch_pack_valid && !rdy) mFull++;
      if (sz == 0 && !fqIf.io_i_flush) mEmpty++;
      if (fqIf.io_i_flush) mFlush++;
`endif
      if (fqIf.io_i_flush) begin
        mq.delete();
      end else begin
        if (fqIf.io_i_decode_ready) begin
          for (int k = 0; k < 2; k++) if (mq.size() > 0 && k < sz) void'(mq.pop_front());
        end
        if (fqIf.io_i_fetch_pack_valid && rdy) begin
          if (fqIf.io_i_fetch_pack_valids_0)
            mq.push_back('{fqIf.io_i_fetch_pack_insts_0, base,
              fqIf.io_i_fetch_pack_branch_predict_pack_valid & fqIf.io_i_fetch_pack_branch_predict_pack_taken
              & (fqIf.io_i_fetch_pack_branch_predict_pack_select == 1'b0)});
          if (fqIf.io_i_fetch_pack_valids_1)
            mq.push_back('{fqIf.io_i_fetch_pack_insts_1, base + 64'd4,
              fqIf.io_i_fetch_pack_branch_predict_pack_valid & fqIf.io_i_fetch_pack_branch_predict_pack_taken
              & (fqIf.io_i_fetch_pack_branch_predict_pack_select == 1'b1)});
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    chk("ready", fqIf.io_o_fetch_pack_ready, (DEPTH - mq.size() >= 2));
    chk("valids_0", fqIf.io_o_decode_valids_0, mq.size() >= 1);
    chk("valids_1", fqIf.io_o_decode_valids_1, mq.size() >= 2);
    if (mq.size() >= 1) begin
      chk("inst_0", fqIf.io_o_decode_insts_0, mq[0].inst);
      chk("pc_0", fqIf.io_o_decode_pcs_0, mq[0].pc);
      chk("pt_0", fqIf.io_o_decode_pred_taken_0, mq[0].pt);
    end
    if (mq.size() >= 2) begin
      chk("inst_1", fqIf.io_o_decode_insts_1, mq[1].inst);
      chk("pc_1", fqIf.io_o_decode_pcs_1, mq[1].pc);
      chk("pt_1", fqIf.io_o_decode_pred_taken_1, mq[1].pt);
    end
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_full", perfFull, mFull);
    chk("perf_empty", perfEmpty, mEmpty);
    chk("perf_flush", perfFlush, mFlush);
`endif
  end

  task automatic setIdle();
    fqIf.io_i_flush = 1'b0;
    fqIf.io_i_fetch_pack_valid = 1'b0;
    fqIf.io_i_fetch_pack_valids_0 = 1'b0;
    fqIf.io_i_fetch_pack_valids_1 = 1'b0;
    fqIf.io_i_fetch_pack_pc = '0;
    fqIf.io_i_fetch_pack_insts_0 = '0;
    fqIf.io_i_fetch_pack_insts_1 = '0;
    fqIf.io_i_fetch_pack_branch_predict_pack_valid = 1'b0;
    fqIf.io_i_fetch_pack_branch_predict_pack_select = 1'b0;
    fqIf.io_i_fetch_pack_branch_predict_pack_taken = 1'b0;
    fqIf.io_i_decode_ready = 1'b0;
  endtask

  // Apply one cycle of inputs, let one edge sample them, return 1 time unit after it.
  task automatic drive(input logic f, input logic pv, input logic [1:0] v, input logic [63:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic bpv, input logic sel, input logic tk, input logic dr);
    fqIf.io_i_flush = f;
    fqIf.io_i_fetch_pack_valid = pv;
    fqIf.io_i_fetch_pack_valids_0 = v[0];
    fqIf.io_i_fetch_pack_valids_1 = v[1];
    fqIf.io_i_fetch_pack_pc = pc;
    fqIf.io_i_fetch_pack_insts_0 = i0;
    fqIf.io_i_fetch_pack_insts_1 = i1;
    fqIf.io_i_fetch_pack_branch_predict_pack_valid = bpv;
    fqIf.io_i_fetch_pack_branch_predict_pack_select = sel;
    fqIf.io_i_fetch_pack_branch_predict_pack_taken = tk;
    fqIf.io_i_decode_ready = dr;
    @(posedge clock);
    #1;
    setIdle();
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 1'b0, 2'b00, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, dr);
  endtask

  task automatic flush();
    drive(1'b1, 1'b0, 2'b00, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fullPack(input int k, input logic dr);
    drive(1'b0, 1'b1, 2'b11, 64'h4000 + 64'(8 * k), 32'hA000_0000 + 32'(2 * k),
          32'hA000_0001 + 32'(2 * k), 1'b1, k[0], 1'b1, dr);
  endtask

  initial begin
    setIdle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valids_0", fqIf.io_o_decode_valids_0, 1'b0);
    chk("reset_ready", fqIf.io_o_fetch_pack_ready, 1'b1);
    reset = 1'b1;
    idle(1'b0);

    // Basic two-slot enqueue; PC low bits dropped.
    drive(1'b0, 1'b1, 2'b11, 64'h8000_0004, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("enq_valids_0", fqIf.io_o_decode_valids_0, 1'b1);
    chk("enq_valids_1", fqIf.io_o_decode_valids_1, 1'b1);
    chk("enq_pc_0", fqIf.io_o_decode_pcs_0, 64'h8000_0000);
    chk("enq_pc_1", fqIf.io_o_decode_pcs_1, 64'h8000_0004);
    chk("enq_inst_0", fqIf.io_o_decode_insts_0, 32'h1111_1111);
    chk("enq_inst_1", fqIf.io_o_decode_insts_1, 32'h2222_2222);
    chk("enq_model_count", mq.size(), 2);
    flush();

    // Compaction: only slot1 valid, predicted taken on slot1.
    drive(1'b0, 1'b1, 2'b10, 64'h1000, 32'hDEAD_0000, 32'h2222_2222, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("cmp_inst_0", fqIf.io_o_decode_insts_0, 32'h2222_2222);
    chk("cmp_pc_0", fqIf.io_o_decode_pcs_0, 64'h1004);
    chk("cmp_pt_0", fqIf.io_o_decode_pred_taken_0, 1'b1);
    chk("cmp_valids_1", fqIf.io_o_decode_valids_1, 1'b0);
    // valids=00 fires but writes nothing.
    drive(1'b0, 1'b1, 2'b00, 64'h2000, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero_pack_valids_1", fqIf.io_o_decode_valids_1, 1'b0);
    flush();

    // Offset head by one so the fill and drain straddle index 15 -> 0.
    drive(1'b0, 1'b1, 2'b01, 64'h3000, 32'hC0DE_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    for (int k = 0; k < 8; k++) fullPack(k, 1'b0);
    chk("fill_ready", fqIf.io_o_fetch_pack_ready, 1'b0);
    chk("fill_model_count", mq.size(), 16);
    fullPack(8, 1'b0);
    chk("fill_reject_count", mq.size(), 16);
    chk("fill_inst_0", fqIf.io_o_decode_insts_0, 32'hA000_0000);
    chk("fill_pc_0", fqIf.io_o_decode_pcs_0, 64'h4000);
    chk("fill_pt_0", fqIf.io_o_decode_pred_taken_0, 1'b1);
    chk("fill_pt_1", fqIf.io_o_decode_pred_taken_1, 1'b0);
    for (int k = 0; k < 8; k++) idle(1'b1);
    chk("drain_empty", fqIf.io_o_decode_valids_0, 1'b0);

    // Full boundary: 15 entries, pack offered while decode drains two.
    flush();
    for (int k = 0; k < 7; k++) fullPack(k, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 64'h5000, 32'hB000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c15_ready", fqIf.io_o_fetch_pack_ready, 1'b0);
    fullPack(20, 1'b1);
    chk("c15_model_count", mq.size(), 13);
    chk("c13_ready", fqIf.io_o_fetch_pack_ready, 1'b1);
    for (int k = 0; k < 7; k++) idle(1'b1);

    // Flush beats simultaneous enqueue and dequeue.
    for (int k = 0; k < 3; k++) fullPack(k, 1'b0);
    chk("pre_flush_count", mq.size(), 6);
    drive(1'b1, 1'b1, 2'b11, 64'h6000, 32'h6, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_valids_0", fqIf.io_o_decode_valids_0, 1'b0);
    chk("flush_model_count", mq.size(), 0);

    // Asynchronous reset in the middle of traffic.
    for (int k = 0; k < 2; k++) fullPack(k, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 64'h7000, 32'hE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", mq.size(), 5);
    reset = 1'b0;
    #1;
    chk("arst_valids_0", fqIf.io_o_decode_valids_0, 1'b0);
    chk("arst_valids_1", fqIf.io_o_decode_valids_1, 1'b0);
    chk("arst_ready", fqIf.io_o_fetch_pack_ready, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b1, 2'b11, 64'h5000, 32'hE000_0000, 32'hE000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_inst_0", fqIf.io_o_decode_insts_0, 32'hE000_0000);
    chk("post_reset_pc_1", fqIf.io_o_decode_pcs_1, 64'h5004);

    // Mixed traffic: partial packs, stalls, drains and occasional flushes together.
    for (int i = 0; i < 300; i++) begin
      drive((i % 41) == 40, (i % 5) != 4, 2'(i), 64'h9000 + 64'(8 * i),
            32'h5000_0000 + 32'(2 * i), 32'h5000_0001 + 32'(2 * i),
            1'b1, i[2], i[3], (i % 3) != 0);
    end
    for (int k = 0; k < 10; k++) idle(1'b1);
    chk("final_empty", fqIf.io_o_decode_valids_0, 1'b0);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
